// File: rtl/conv_module_pkg.sv
// Purpose : shared sizes, FSM state encoding and int8 saturation helper for conv_module.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: IMG/K/OUT/NKER/DW/ACCW sizes, derived TAPS/NPOS, ST_* states, sat8().
package conv_module_pkg;

  localparam int IMG  = 8;   // input image is IMG x IMG, one channel
  localparam int K    = 3;   // kernel is K x K
  localparam int OUT  = 6;   // output plane is OUT x OUT (IMG-K+1)
  localparam int NKER = 3;   // number of kernels / output channels
  localparam int DW   = 8;   // pixel, weight and result width (signed)
  localparam int ACCW = 20;  // accumulator width, 9 x 16-bit products fit

  localparam int TAPS = K * K;
  localparam int NPOS = OUT * OUT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(127);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-128);

  // Clamp a wide signed sum into the int8 range.
  function automatic logic [DW-1:0] sat8(input logic signed [ACCW-1:0] v);
    if (v > SAT_MAX) begin
      return 8'h7F;
    end else if (v < SAT_MIN) begin
      return 8'h80;
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/conv_module_pe.sv
// Purpose : one 3x3 signed int8 dot product, saturated to int8 (module conv_pe).
// Latency : combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports   : pix = 9 window pixels (tap kr*3+kc), wgt = 9 weights (same order), res = int8.
module conv_pe
  import conv_module_pkg::*;
(
  input  logic [TAPS*DW-1:0] pix,
  input  logic [TAPS*DW-1:0] wgt,
  output logic [DW-1:0]      res
);

  logic signed [ACCW-1:0] acc;
  logic signed [2*DW-1:0] prod;

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int t = 0; t < TAPS; t++) begin
      prod = $signed(pix[t*DW +: DW]) * $signed(wgt[t*DW +: DW]);
      // size cast of a signed value sign-extends into the accumulator
      acc  = acc + ACCW'(prod);
    end
    res = sat8(acc);
  end

endmodule

// File: rtl/conv_module.sv
// Purpose : 8x8 int8 image x three 3x3 kernels -> 6x6x3 int8 cross-correlation, one output position per cycle.
// Latency : out_vld pulses 37 edges after the capture edge; next capture possible on the edge out_vld falls.
// Backpressure: none; in_vld is only sampled while idle, inputs are ignored while busy.
// Ports   : clk, rst_n (sync, active-high), in_vld, data_lin[511:0], weight_lin[215:0] -> conv_lin[863:0], out_vld.
module conv_module
  import conv_module_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic [IMG*IMG*DW-1:0]     data_lin,
  input  logic [NKER*TAPS*DW-1:0]   weight_lin,
  output logic [NKER*NPOS*DW-1:0]   conv_lin,
  output logic                      out_vld
);

  logic [1:0]                state;
  logic [5:0]                pos;   // raster index row*OUT+col of the position being written
  logic [2:0]                row;
  logic [2:0]                col;
  logic [IMG*IMG*DW-1:0]     data_q;
  logic [NKER*TAPS*DW-1:0]   weight_q;
  logic [TAPS*DW-1:0]        win;
  logic [DW-1:0]             pe_res [NKER];

  // Row/col are kept alongside pos so the window address needs no divide by 6.
  always_comb begin
    win = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        win[(kr*K + kc)*DW +: DW] =
          data_q[((int'(row) + kr)*IMG + int'(col) + kc)*DW +: DW];
      end
    end
  end

  // The same window feeds all kernels; each PE sees its own 9 weights.
  for (genvar k = 0; k < NKER; k++) begin : g_pe
    conv_pe u_pe (
      .pix (win),
      .wgt (weight_q[k*TAPS*DW +: TAPS*DW]),
      .res (pe_res[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      pos      <= '0;
      row      <= '0;
      col      <= '0;
      out_vld  <= 1'b0;
      conv_lin <= '0;
      data_q   <= '0;
      weight_q <= '0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_vld) begin
            data_q   <= data_lin;
            weight_q <= weight_lin;
            pos      <= '0;
            row      <= '0;
            col      <= '0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          for (int k = 0; k < NKER; k++) begin
            conv_lin[(k*NPOS + int'(pos))*DW +: DW] <= pe_res[k];
          end
          if (pos == 6'(NPOS-1)) begin
            state <= ST_DONE;
          end else begin
            pos <= pos + 6'd1;
            if (col == 3'(OUT-1)) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        ST_DONE: begin
          // registered pulse: high for the single cycle after this edge
          out_vld <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_module.sv
// Purpose : self-checking bench for conv_module (table vectors, random golden model, reset/mid-change corners).
// Latency : checks the 37-edge capture-to-out_vld latency and one-cycle pulse.
// Backpressure: exercises in_vld held high back-to-back and inputs changing while busy.
module tb_conv_module;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  logic [511:0] data_lin;
  logic [215:0] weight_lin;
  logic [863:0] conv_lin;
  logic         out_vld;

  int vectors;
  int miscompares;

  conv_module dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .data_lin   (data_lin),
    .weight_lin (weight_lin),
    .conv_lin   (conv_lin),
    .out_vld    (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [511:0] d;
    logic [215:0] w;
    logic [863:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [863:0] got, input logic [863:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference: unpack to integer planes, correlate, clamp, repack.
  function automatic logic [863:0] golden(input logic [511:0] d, input logic [215:0] w);
    int img [8][8];
    int ker [3][3][3];
    int s;
    logic [863:0] o;
    logic [7:0] b;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      b = d[i*8 +: 8];
      img[i/8][i%8] = int'($signed(b));
    end
    for (int i = 0; i < 27; i++) begin
      b = w[i*8 +: 8];
      ker[i/9][(i%9)/3][i%3] = int'($signed(b));
    end
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          s = 0;
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
              s += img[r+kr][c+kc] * ker[k][kr][kc];
          if (s > 127) s = 127;
          if (s < -128) s = -128;
          o[(k*36 + r*6 + c)*8 +: 8] = 8'(s);
        end
    return o;
  endfunction

  // mode 0: full-range bytes, mode 1: small bytes in -8..7
  function automatic logic [511:0] rand_data(input int mode);
    logic [511:0] v;
    for (int i = 0; i < 64; i++)
      v[i*8 +: 8] = (mode == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) - 8);
    return v;
  endfunction

  function automatic logic [215:0] rand_wgt(input int mode);
    logic [215:0] v;
    for (int i = 0; i < 27; i++)
      v[i*8 +: 8] = (mode == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) - 8);
    return v;
  endfunction

  // Presents an image, waits (bounded) for out_vld, checks pulse shape, latency and result.
  task automatic run_image(input string name, input logic [511:0] d, input logic [215:0] w,
                           input logic [863:0] exp, input bit keep, input bit mid_change);
    int n;
    data_lin   = d;
    weight_lin = w;
    in_vld     = 1'b1;
    @(posedge clk); #1;
    chk({name, "_pulse_low"}, 864'(out_vld), 864'(0));
    if (!keep) in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (mid_change && n == 10) begin
        data_lin   = rand_data(0);
        weight_lin = rand_wgt(0);
      end
    end
    chk({name, "_latency"}, 864'(n), 864'(37));
    chk({name, "_result"}, conv_lin, exp);
  endtask

  initial begin
    logic [511:0] d;
    logic [215:0] w;
    logic [863:0] e;
    int s;
    bit seen;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    in_vld      = 1'b0;
    data_lin    = '0;
    weight_lin  = '0;

    // all ones -> 9 everywhere
    tbl[0].d = {64{8'h01}}; tbl[0].w = {27{8'h01}}; tbl[0].exp = {108{8'h09}};
    // positive overflow and negative overflow
    tbl[1].d = {64{8'h7F}}; tbl[1].w = {27{8'h7F}}; tbl[1].exp = {108{8'h7F}};
    tbl[2].d = {64{8'h7F}}; tbl[2].w = {27{8'h80}}; tbl[2].exp = {108{8'h80}};
    // ramp image, centre-tap / zero / all -1 kernels, expectations by closed form
    d = '0; w = '0; e = '0;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
    w[4*8 +: 8] = 8'h01;
    for (int t = 18; t < 27; t++) w[t*8 +: 8] = 8'hFF;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        e[(r*6 + c)*8 +: 8] = 8'((r+1)*8 + (c+1));
        s = -(9*(8*r + c) + 81);
        if (s < -128) s = -128;
        e[(72 + r*6 + c)*8 +: 8] = 8'(s);
      end
    tbl[3].d = d; tbl[3].w = w; tbl[3].exp = e;

    // reset state
    data_lin   = {64{8'h55}};
    weight_lin = {27{8'h33}};
    in_vld     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_vld", 864'(out_vld), 864'(0));
    chk("reset_conv_lin", conv_lin, 864'(0));
    in_vld = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_image($sformatf("tbl%0d", i), tbl[i].d, tbl[i].w, tbl[i].exp, 1'b0, 1'b0);

    // result holds after the pulse while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold_after_pulse", conv_lin, tbl[3].exp);
    chk("idle_no_pulse", 864'(out_vld), 864'(0));

    // 100 random images, in_vld held high, new data 1 ns after each pulse
    for (int i = 0; i < 100; i++) begin
      d = rand_data(i % 2);
      w = rand_wgt((i / 2) % 2);
      run_image($sformatf("rnd%0d", i), d, w, golden(d, w), 1'b1, 1'b0);
    end
    in_vld = 1'b0;
    @(posedge clk); #1;

    // inputs changing mid-calculation must not disturb the result
    d = rand_data(1);
    w = rand_wgt(1);
    run_image("mid_change", d, w, golden(d, w), 1'b0, 1'b1);
    @(posedge clk); #1;

    // reset at pos 20 aborts the image
    d = rand_data(0);
    w = rand_wgt(1);
    data_lin   = d;
    weight_lin = w;
    in_vld     = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("abort_conv_lin", conv_lin, 864'(0));
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_vld) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_pulse", 864'(seen), 864'(0));
    run_image("restart", d, w, golden(d, w), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
